// File: rtl/rxpy_word_packer_pkg.sv
// ============================================================================
// rxpy_word_packer_pkg : shared rx buffer constants and packer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package rxpy_word_packer_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PACK  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } pk_state_t;

endpackage

`default_nettype wire

// File: rtl/rxpy_word_packer.sv
// ============================================================================
// rxpy_word_packer : packs the decoded payload bitstream LSB-first into 32-bit
//                    words on the rx buffer write port
// Rev 1.0
// ============================================================================
`default_nettype none

module rxpy_word_packer
   import rxpy_word_packer_pkg::*;
(
   input  logic              clk_6M,
   input  logic              rst,
   input  logic              dec_py_st_p,
   input  logic              dec_py_period,
   input  logic              dec_pybit,
   input  logic              dec_pybit_valid,
   input  logic              dec_pylen_valid_p,
   input  logic [9:0]        dec_pylenByte,
   output logic [ADDR_W-1:0] rxlnctrl_addr,
   output logic [WORD_W-1:0] rxlnctrl_din,
   output logic              rxlnctrl_we,
   output logic [CNT_W-1:0]  rxpy_bitcount,
   output logic              rxpy_done_p,
   output logic              rxpy_ovf
);

   // One extra counter bit marks the fully used 8192-bit buffer.
   pk_state_t         state_q, state_d;
   logic [CNT_W:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  lim_q, lim_d;
   logic              lim_en_q, lim_en_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] din_q, din_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              period_q;

   logic [WORD_W-1:0] w_shreg_ins;
   logic              w_below_lim;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      lim_d       = lim_q;
      lim_en_d    = lim_en_q;
      ovf_d       = ovf_q;
      addr_d      = addr_q;
      din_d       = din_q;
      we_d        = 1'b0;
      w_shreg_ins = shreg_q;
      w_below_lim = 1'b0;

      if (dec_py_st_p) begin
         state_d  = ST_PACK;
         cnt_d    = '0;
         shreg_d  = '0;
         ovf_d    = 1'b0;
         lim_en_d = 1'b0;
         lim_d    = '0;
      end else begin
         case (state_q)
            ST_PACK: begin
               if (dec_pylen_valid_p) begin
                  lim_en_d = 1'b1;
                  lim_d    = {dec_pylenByte, 3'b000};
               end
               w_below_lim = !lim_en_d || (cnt_q < {1'b0, lim_d});
               if (dec_pybit_valid && dec_py_period) begin
                  if (cnt_q[CNT_W]) begin
                     ovf_d   = 1'b1;
                     state_d = ST_FLUSH;
                  end else if (w_below_lim) begin
                     w_shreg_ins[cnt_q[4:0]] = dec_pybit;
                     cnt_d = cnt_q + (CNT_W+1)'(1);
                     if (&cnt_q[4:0]) begin
                        // Completed word moves to the output register so the
                        // shift register is free for the next bit immediately.
                        we_d    = 1'b1;
                        addr_d  = cnt_q[CNT_W-1:5];
                        din_d   = w_shreg_ins;
                        shreg_d = '0;
                     end else begin
                        shreg_d = w_shreg_ins;
                     end
                  end
               end
               if (lim_en_d && (cnt_d >= {1'b0, lim_d}))
                  state_d = ST_FLUSH;
               if (period_q && !dec_py_period)
                  state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
               if (cnt_q[4:0] != 5'd0) begin
                  we_d   = 1'b1;
                  addr_d = cnt_q[CNT_W-1:5];
                  din_d  = shreg_q;
               end
               state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_6M or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         lim_q    <= '0;
         lim_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         period_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         lim_q    <= lim_d;
         lim_en_q <= lim_en_d;
         ovf_q    <= ovf_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
         done_q   <= done_d;
         period_q <= dec_py_period;
      end
   end

   assign rxlnctrl_addr = addr_q;
   assign rxlnctrl_din  = din_q;
   assign rxlnctrl_we   = we_q;
   assign rxpy_bitcount = cnt_q[CNT_W-1:0];
   assign rxpy_done_p   = done_q;
   assign rxpy_ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rxpy_word_packer.sv
// ============================================================================
// tb_rxpy_word_packer : directed self-checking bench for rxpy_word_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rxpy_word_packer;

   logic        clk_6M = 1'b0;
   logic        rst;
   logic        dec_py_st_p;
   logic        dec_py_period;
   logic        dec_pybit;
   logic        dec_pybit_valid;
   logic        dec_pylen_valid_p;
   logic [9:0]  dec_pylenByte;
   logic [7:0]  rxlnctrl_addr;
   logic [31:0] rxlnctrl_din;
   logic        rxlnctrl_we;
   logic [12:0] rxpy_bitcount;
   logic        rxpy_done_p;
   logic        rxpy_ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // write / done log filled on the falling edge
   int          wr_n   = 0;
   int          done_n = 0;
   logic [7:0]  wr_addr [0:299];
   logic [31:0] wr_din  [0:299];
   int          wr_cyc  [0:299];

   rxpy_word_packer dut (
      .clk_6M            (clk_6M),
      .rst               (rst),
      .dec_py_st_p       (dec_py_st_p),
      .dec_py_period     (dec_py_period),
      .dec_pybit         (dec_pybit),
      .dec_pybit_valid   (dec_pybit_valid),
      .dec_pylen_valid_p (dec_pylen_valid_p),
      .dec_pylenByte     (dec_pylenByte),
      .rxlnctrl_addr     (rxlnctrl_addr),
      .rxlnctrl_din      (rxlnctrl_din),
      .rxlnctrl_we       (rxlnctrl_we),
      .rxpy_bitcount     (rxpy_bitcount),
      .rxpy_done_p       (rxpy_done_p),
      .rxpy_ovf          (rxpy_ovf)
   );

   always #5 clk_6M = ~clk_6M;

   always @(posedge clk_6M) cyc <= cyc + 1;

   always @(negedge clk_6M) begin
      if (rxlnctrl_we && wr_n < 300) begin
         wr_addr[wr_n] = rxlnctrl_addr;
         wr_din[wr_n]  = rxlnctrl_din;
         wr_cyc[wr_n]  = cyc;
         wr_n          = wr_n + 1;
      end
      if (rxpy_done_p) done_n = done_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_6M);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bit(input logic b);
      dec_pybit       = b;
      dec_pybit_valid = 1'b1;
      tick();
      dec_pybit_valid = 1'b0;
   endtask

   task automatic start_py();
      dec_py_st_p = 1'b1;
      tick();
      dec_py_st_p = 1'b0;
   endtask

   task automatic pylen(input logic [9:0] n);
      dec_pylenByte     = n;
      dec_pylen_valid_p = 1'b1;
      tick();
      dec_pylen_valid_p = 1'b0;
   endtask

   task automatic clr_log();
      wr_n   = 0;
      done_n = 0;
   endtask

   initial begin
      int s31, s63, bad;
      rst               = 1'b1;
      dec_py_st_p       = 1'b0;
      dec_py_period     = 1'b0;
      dec_pybit         = 1'b0;
      dec_pybit_valid   = 1'b0;
      dec_pylen_valid_p = 1'b0;
      dec_pylenByte     = 10'd0;
      idle(2);
      chk("rst_we",    {31'd0, rxlnctrl_we}, 32'd0);
      chk("rst_addr",  {24'd0, rxlnctrl_addr}, 32'd0);
      chk("rst_din",   rxlnctrl_din, 32'd0);
      chk("rst_cnt",   {19'd0, rxpy_bitcount}, 32'd0);
      chk("rst_done",  {31'd0, rxpy_done_p}, 32'd0);
      chk("rst_ovf",   {31'd0, rxpy_ovf}, 32'd0);
      rst = 1'b0;
      idle(2);

      // 64 alternating bits, length 8 bytes
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      pylen(10'd8);
      s31 = 0; s63 = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 31) s31 = cyc;
         if (i == 63) s63 = cyc;
         send_bit((i % 2) == 0);
      end
      idle(4);
      dec_py_period = 1'b0;
      idle(2);
      chk("t1_nwr",   wr_n, 2);
      chk("t1_addr0", {24'd0, wr_addr[0]}, 32'd0);
      chk("t1_din0",  wr_din[0], 32'h5555_5555);
      chk("t1_lat0",  wr_cyc[0], s31 + 1);
      chk("t1_addr1", {24'd0, wr_addr[1]}, 32'd1);
      chk("t1_din1",  wr_din[1], 32'h5555_5555);
      chk("t1_lat1",  wr_cyc[1], s63 + 1);
      chk("t1_done",  done_n, 1);
      chk("t1_cnt",   {19'd0, rxpy_bitcount}, 32'd64);
      chk("t1_hold",  {24'd0, rxlnctrl_addr}, 32'd1);

      // length 5 bytes, 40 ones at one strobe per 6 cycles, then 8 extras
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      pylen(10'd5);
      for (int i = 0; i < 48; i++) begin
         send_bit(1'b1);
         idle(5);
      end
      dec_py_period = 1'b0;
      idle(3);
      chk("t2_nwr",   wr_n, 2);
      chk("t2_addr0", {24'd0, wr_addr[0]}, 32'd0);
      chk("t2_din0",  wr_din[0], 32'hFFFF_FFFF);
      chk("t2_addr1", {24'd0, wr_addr[1]}, 32'd1);
      chk("t2_din1",  wr_din[1], 32'h0000_00FF);
      chk("t2_done",  done_n, 1);
      chk("t2_cnt",   {19'd0, rxpy_bitcount}, 32'd40);

      // period falls after 10 ones, no length
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      idle(1);
      dec_py_period = 1'b0;
      idle(4);
      chk("t3_nwr",  wr_n, 1);
      chk("t3_addr", {24'd0, wr_addr[0]}, 32'd0);
      chk("t3_din",  wr_din[0], 32'h0000_03FF);
      chk("t3_done", done_n, 1);
      chk("t3_cnt",  {19'd0, rxpy_bitcount}, 32'd10);

      // restart mid-payload after 20 bits
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      start_py();
      idle(2);
      chk("t4_nwr_a",  wr_n, 0);
      chk("t4_done_a", done_n, 0);
      chk("t4_cnt_a",  {19'd0, rxpy_bitcount}, 32'd0);
      for (int i = 0; i < 32; i++) send_bit(i < 4);
      idle(2);
      dec_py_period = 1'b0;
      idle(4);
      chk("t4_nwr_b",  wr_n, 1);
      chk("t4_addr",   {24'd0, wr_addr[0]}, 32'd0);
      chk("t4_din",    wr_din[0], 32'h0000_000F);
      chk("t4_done_b", done_n, 1);
      chk("t4_cnt_b",  {19'd0, rxpy_bitcount}, 32'd32);

      // zero length
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      pylen(10'd0);
      tick();
      chk("t5_donep", {31'd0, rxpy_done_p}, 32'd1);
      send_bit(1'b1);
      idle(3);
      dec_py_period = 1'b0;
      idle(2);
      chk("t5_nwr",  wr_n, 0);
      chk("t5_done", done_n, 1);

      // 8193 strobes, no length: fill the buffer then overflow
      clr_log();
      start_py();
      dec_py_period = 1'b1;
      for (int i = 0; i < 8193; i++) send_bit(1'b1);
      idle(4);
      dec_py_period = 1'b0;
      idle(2);
      chk("t6_nwr",  wr_n, 256);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (wr_addr[i] !== 8'(i) || wr_din[i] !== 32'hFFFF_FFFF) bad++;
      chk("t6_seq",  bad, 0);
      chk("t6_last", {24'd0, rxlnctrl_addr}, 32'd255);
      chk("t6_ovf",  {31'd0, rxpy_ovf}, 32'd1);
      chk("t6_done", done_n, 1);
      start_py();
      chk("t6_ovfclr", {31'd0, rxpy_ovf}, 32'd0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rxpy_word_packer.md
Name: rxpy_word_packer

Overview:
- Rx-side stage directly upstream of the payload buffer controller.
- Takes the serial decoded payload bitstream (post-FEC/whitening) and packs it LSB-first into 32-bit words.
- Drives the rx buffer write port: rxlnctrl_addr / rxlnctrl_din / rxlnctrl_we. The buffer controller steers that port to the ACL or SCO rx buffer.
- Bit order mirrors tx side: payload bit n lands in word n[12:5], bit position n[4:0].

Parameters:
WORD_W, 32, buffer word width (fixed; bit index = 5 LSBs of count)
ADDR_W, 8, word address width (256 words = 8192 bits max per payload)
CNT_W, 13, payload bit counter width (= ADDR_W + 5)

Ports:
clk_6M  in  1  system clock, 6 MHz
rst  in  1  asynchronous, active-high reset
dec_py_st_p  in  1  one-cycle pulse: first payload bit follows; (re)starts packer
dec_py_period  in  1  high while payload field is being decoded
dec_pybit  in  1  decoded payload bit
dec_pybit_valid  in  1  strobe qualifying dec_pybit; may be high on consecutive cycles
dec_pylen_valid_p  in  1  one-cycle pulse: dec_pylenByte now valid (after payload header decode)
dec_pylenByte  in  10  payload body length in bytes, CRC excluded
rxlnctrl_addr  out  8  buffer word address
rxlnctrl_din  out  32  buffer write data
rxlnctrl_we  out  1  one-cycle write strobe
rxpy_bitcount  out  13  number of bits accepted in current payload
rxpy_done_p  out  1  one-cycle pulse: last word written, payload complete
rxpy_ovf  out  1  sticky: payload exceeded 8192 bits; cleared by dec_py_st_p

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, shift register 0, length limit disabled.
- States: IDLE, PACK, FLUSH, DONE.
- IDLE -> PACK on dec_py_st_p. Entry clears bitcount, shift register, ovf, and the length limit (limit disabled).
- PACK, on dec_pybit_valid & dec_py_period & below limit:
  - shreg[bitcount[4:0]] <= dec_pybit; bitcount++.
  - When the accepted bit has bitcount[4:0]==31: next cycle we=1, addr=bitcount[12:5] (pre-increment value), din = completed word. Shreg clears in the same cycle so the next bit can be accepted back-to-back; output data is held in a separate register.
- Write latency: 1 clock from the strobe of the 32nd bit to we.
- dec_pylen_valid_p in PACK: latch limit = dec_pylenByte*8 (13-bit, no truncation since max 8184). If bitcount >= limit already: go to FLUSH immediately; bits beyond limit are discarded.
- Reaching limit (bitcount becomes == limit): go to FLUSH; further strobes ignored.
- Falling dec_py_period in PACK: go to FLUSH.
- FLUSH:
  - If bitcount[4:0] != 0: one write with addr=bitcount[12:5], din=shreg (unfilled upper bits 0), then DONE.
  - If bitcount[4:0]==0: no write, DONE next cycle.
  - If a full-word write is still pending from the previous cycle, it completes first; never two writes in one cycle.
- DONE: rxpy_done_p=1 for one cycle, then IDLE. bitcount holds until the next dec_py_st_p.
- Limit 0 (dec_pylenByte=0): FLUSH immediately, no writes, done pulse.
- Overflow: a strobe arriving when bitcount==8192-capacity (8191 accepted + final bit fills word 255) completes that write. Any further strobe in PACK sets rxpy_ovf, is discarded, and goes to FLUSH. Address never wraps.
- dec_py_st_p in any state: immediate restart into PACK. Any partial word is discarded (no write); a pending full-word write in the same cycle is suppressed. No done pulse.
- Strobes in IDLE/DONE or with dec_py_period low: ignored.
- rxlnctrl_addr/din hold their last value when we=0.

Decomposition:
- Shared package (existing rx buffer constants): WORD_W, ADDR_W, CNT_W, state encoding (IDLE=0, PACK=1, FLUSH=2, DONE=3).
- Single module; no sub-module. Shift/hold register and FSM are small.

Test Plan:
- st_p, then 64 valid bits alternating 1,0 on consecutive cycles, period high, pylenByte=8 -> two writes: addr 0/1, din 32'h5555_5555 each, 1 cycle after bits 31/63; done pulse; bitcount=64.
- pylenByte=5, 40 bits of 1, strobes every 6 cycles -> write addr0 din FFFF_FFFF; FLUSH write addr1 din 0000_00FF; done; extra 8 strobes ignored, bitcount=40.
- period falls after 10 bits of 1, no length latched -> single write addr0 din 0000_03FF, done.
- st_p asserted after 20 bits -> no write, no done; new payload restarts at addr0, bitcount 0.
- pylenByte=0 at pylen_valid_p -> no writes, done pulse within 2 cycles.
- 8193 strobes, no length -> 256 writes addr 0..255, ovf=1, addr never wraps to 0, done; next st_p clears ovf.
